mem_req_queue: RTL and testbench

- Sits directly downstream of the 3-port cache-refill crossbar, between its merged memory request/response port and the backend memory controller.
- Buffers up to DEPTH requests (rw, addr, tag) in order and forwards them to the backend with a val/rdy handshake.
- Registers backend responses back toward the crossbar.
- Detects read-after-queued-write hazards and answers the offending read with a tagged nack instead of enqueueing it.

---
 rtl/mem_req_queue_pkg.sv | 12 +
 rtl/mem_req_queue_ram.sv | 46 ++++
 rtl/mem_req_queue.sv | 111 +++++++++++
 tb/tb_mem_req_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_queue_pkg.sv
// Shared types for the memory request queue. Widths match the riscv memory
// interface constants (MEM_ADDR_BITS / MEM_TAG_BITS).
package mem_req_queue_pkg;
    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_TAG_BITS  = 8;

    typedef struct packed {
        logic                     rw;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_TAG_BITS-1:0]  tag;
    } mem_req_t;
endpackage

// File: rtl/mem_req_queue_ram.sv
// DEPTH-entry request storage: one write port, one async read port, plus
// per-entry (valid & write) mask and addresses for the hazard comparator.
module mem_req_queue_ram
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_we,
    input  logic [PTR_BITS-1:0]                   i_waddr,
    input  mem_req_t                              i_wdata,
    input  logic                                  i_re,
    input  logic [PTR_BITS-1:0]                   i_raddr,
    output mem_req_t                              o_rdata,
    output logic [DEPTH-1:0]                      o_wr_mask,
    output logic [DEPTH-1:0][MEM_ADDR_BITS-1:0]   o_addr
);
    mem_req_t         r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read and write never target the same slot in one cycle: that only
    // happens when the queue is empty (no read) or full (no write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            if (i_re) r_vld[i_raddr] <= 1'b0;
            if (i_we) r_vld[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata = r_mem[i_raddr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_wr_mask[i] = r_vld[i] & r_mem[i].rw;
            o_addr[i]    = r_mem[i].addr;
        end
    end
endmodule

// File: rtl/mem_req_queue.sv
// In-order memory request queue between the refill crossbar and the backend,
// with a registered response path and read-after-queued-write nacks.
module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_val,
    output logic                     mem_req_rdy,
    input  logic                     mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]  mem_req_tag,
    output logic                     mem_resp_val,
    output logic                     mem_resp_nack,
    output logic [MEM_TAG_BITS-1:0]  mem_resp_tag,
    output logic                     back_req_val,
    input  logic                     back_req_rdy,
    output logic                     back_req_rw,
    output logic [MEM_ADDR_BITS-1:0] back_req_addr,
    output logic [MEM_TAG_BITS-1:0]  back_req_tag,
    input  logic                     back_resp_val,
    input  logic [MEM_TAG_BITS-1:0]  back_resp_tag,
    output logic                     idle
);
    localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);

    logic [PTR_BITS:0]    r_count;
    logic [PTR_BITS-1:0]  r_wr_ptr, r_rd_ptr;
    logic                 r_nack_pend;
    logic [MEM_TAG_BITS-1:0] r_nack_tag;

    logic w_accept, w_deq, w_hit, w_enq, w_nack_set;
    mem_req_t                           w_wdata, w_head;
    logic [DEPTH-1:0]                   w_wr_mask;
    logic [DEPTH-1:0][MEM_ADDR_BITS-1:0] w_addr;

    assign mem_req_rdy = (r_count != FULL) & ~r_nack_pend;
    assign back_req_val = (r_count != '0);
    assign idle         = (r_count == '0) & ~r_nack_pend;

    assign w_accept = mem_req_val & mem_req_rdy;
    assign w_deq    = back_req_val & back_req_rdy;

    // Conservative: the entry leaving this cycle still counts as a hazard.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (w_wr_mask[i] && (w_addr[i] == mem_req_addr)) w_hit = 1'b1;
    end

    assign w_nack_set = w_accept & ~mem_req_rw & w_hit;
    assign w_enq      = w_accept & ~w_nack_set;
    assign w_wdata    = '{rw: mem_req_rw, addr: mem_req_addr, tag: mem_req_tag};

    mem_req_queue_ram #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_enq),
        .i_waddr   (r_wr_ptr),
        .i_wdata   (w_wdata),
        .i_re      (w_deq),
        .i_raddr   (r_rd_ptr),
        .o_rdata   (w_head),
        .o_wr_mask (w_wr_mask),
        .o_addr    (w_addr)
    );

    assign back_req_rw   = w_head.rw;
    assign back_req_addr = w_head.addr;
    assign back_req_tag  = w_head.tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Backend responses win; a pending nack waits and blocks new requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nack_pend   <= 1'b0;
            r_nack_tag    <= '0;
            mem_resp_val  <= 1'b0;
            mem_resp_nack <= 1'b0;
            mem_resp_tag  <= '0;
        end else begin
            mem_resp_val  <= back_resp_val;
            mem_resp_nack <= r_nack_pend & ~back_resp_val;
            mem_resp_tag  <= back_resp_val ? back_resp_tag : r_nack_tag;
            if (w_nack_set) begin
                r_nack_pend <= 1'b1;
                r_nack_tag  <= mem_req_tag;
            end else if (r_nack_pend & ~back_resp_val) begin
                r_nack_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: directed vector table, hand-written full/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_mem_req_queue;
    localparam int DEPTH = 4;

    logic        clk = 0, reset = 1;
    logic        mem_req_val = 0, mem_req_rw = 0;
    logic [31:0] mem_req_addr = 0;
    logic [7:0]  mem_req_tag = 0;
    logic        back_req_rdy = 0, back_resp_val = 0;
    logic [7:0]  back_resp_tag = 0;
    logic        mem_req_rdy, mem_resp_val, mem_resp_nack, back_req_val, back_req_rw, idle;
    logic [7:0]  mem_resp_tag, back_req_tag;
    logic [31:0] back_req_addr;

    int checks = 0, failures = 0;

    mem_req_queue #(.DEPTH(DEPTH), .PTR_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack), .mem_resp_tag(mem_resp_tag),
        .back_req_val(back_req_val), .back_req_rdy(back_req_rdy), .back_req_rw(back_req_rw),
        .back_req_addr(back_req_addr), .back_req_tag(back_req_tag),
        .back_resp_val(back_resp_val), .back_resp_tag(back_resp_tag), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit rw, input logic [31:0] a, input logic [7:0] t,
                         input bit brdy, input bit rv, input logic [7:0] rt);
        mem_req_val = v; mem_req_rw = rw; mem_req_addr = a; mem_req_tag = t;
        back_req_rdy = brdy; back_resp_val = rv; back_resp_tag = rt;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    typedef struct {
        bit v; bit rw; logic [31:0] a; logic [7:0] t; bit brdy; bit rv; logic [7:0] rt;
        bit e_rdy; bit e_bval; logic [31:0] e_baddr; bit e_rv; bit e_rn; logic [7:0] e_rt; bit e_idle;
    } vec_t;

    function automatic vec_t mk(bit v, bit rw, logic [31:0] a, logic [7:0] t, bit brdy, bit rv,
                                logic [7:0] rt, bit e_rdy, bit e_bval, logic [31:0] e_baddr,
                                bit e_rv, bit e_rn, logic [7:0] e_rt, bit e_idle);
        vec_t r;
        r.v = v; r.rw = rw; r.a = a; r.t = t; r.brdy = brdy; r.rv = rv; r.rt = rt;
        r.e_rdy = e_rdy; r.e_bval = e_bval; r.e_baddr = e_baddr;
        r.e_rv = e_rv; r.e_rn = e_rn; r.e_rt = e_rt; r.e_idle = e_idle;
        return r;
    endfunction

    // Reference model state
    typedef struct { bit rw; logic [31:0] a; logic [7:0] t; } ent_t;
    ent_t m_q[$];
    bit   m_np, m_rv, m_rn;
    logic [7:0] m_ntag, m_rt;

    vec_t tv[17];

    initial begin
        // reset state
        reset = 1;
        #12;
        check("rst_rdy", mem_req_rdy, 1);
        check("rst_bval", back_req_val, 0);
        check("rst_rv", mem_resp_val, 0);
        check("rst_rn", mem_resp_nack, 0);
        check("rst_rt", mem_resp_tag, 0);
        check("rst_idle", idle, 1);

        // directed table: inputs applied this cycle, outputs expected this cycle
        tv[0]  = mk(1,0,'h10,'h01,1,0,0,   1,0,'h00,0,0,'h00,1);
        tv[1]  = mk(1,0,'h20,'h02,1,0,0,   1,1,'h10,0,0,'h00,0);
        tv[2]  = mk(1,0,'h30,'h03,1,0,0,   1,1,'h20,0,0,'h00,0);
        tv[3]  = mk(0,0,'h00,'h00,1,0,0,   1,1,'h30,0,0,'h00,0);
        tv[4]  = mk(1,1,'h40,'h04,0,0,0,   1,0,'h00,0,0,'h00,1);
        tv[5]  = mk(1,0,'h40,'h81,0,0,0,   1,1,'h40,0,0,'h00,0);
        tv[6]  = mk(1,0,'h50,'h09,0,0,0,   0,1,'h40,0,0,'h00,0);
        tv[7]  = mk(1,0,'h40,'h82,0,0,0,   1,1,'h40,0,1,'h81,0);
        tv[8]  = mk(0,0,'h00,'h00,0,1,'h05,0,1,'h40,0,0,'h00,0);
        tv[9]  = mk(0,0,'h00,'h00,0,1,'h05,0,1,'h40,1,0,'h05,0);
        tv[10] = mk(0,0,'h00,'h00,0,0,0,   0,1,'h40,1,0,'h05,0);
        tv[11] = mk(0,0,'h00,'h00,1,0,0,   1,1,'h40,0,1,'h82,0);
        tv[12] = mk(1,0,'h50,'h06,0,0,0,   1,0,'h00,0,0,'h00,1);
        tv[13] = mk(1,0,'h50,'h07,0,0,0,   1,1,'h50,0,0,'h00,0);
        tv[14] = mk(0,0,'h00,'h00,1,0,0,   1,1,'h50,0,0,'h00,0);
        tv[15] = mk(0,0,'h00,'h00,1,0,0,   1,1,'h50,0,0,'h00,0);
        tv[16] = mk(0,0,'h00,'h00,0,0,0,   1,0,'h00,0,0,'h00,1);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].v, tv[i].rw, tv[i].a, tv[i].t, tv[i].brdy, tv[i].rv, tv[i].rt);
            check($sformatf("tv%0d_rdy", i), mem_req_rdy, tv[i].e_rdy);
            check($sformatf("tv%0d_bval", i), back_req_val, tv[i].e_bval);
            if (tv[i].e_bval) check($sformatf("tv%0d_baddr", i), back_req_addr, tv[i].e_baddr);
            check($sformatf("tv%0d_rv", i), mem_resp_val, tv[i].e_rv);
            check($sformatf("tv%0d_rn", i), mem_resp_nack, tv[i].e_rn);
            if (tv[i].e_rv || tv[i].e_rn) check($sformatf("tv%0d_rt", i), mem_resp_tag, tv[i].e_rt);
            check($sformatf("tv%0d_idle", i), idle, tv[i].e_idle);
            @(negedge clk);
        end

        // full queue: 5 writes offered with the backend stalled
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("full_acc_rdy", mem_req_rdy, 1);
            drive(1, 1, 'h100 + k, 8'(k), 0, 0, 0);
            @(negedge clk);
        end
        drive(1, 1, 'h104, 8'h04, 0, 0, 0);
        check("full_rdy0", mem_req_rdy, 0);
        @(negedge clk);
        check("full_still0", mem_req_rdy, 0);
        back_req_rdy = 1;
        @(negedge clk);
        back_req_rdy = 0;
        check("full_rdy_back", mem_req_rdy, 1);
        check("full_head", back_req_addr, 'h101);
        @(negedge clk);
        mem_req_val = 0;
        check("full_refull", mem_req_rdy, 0);
        back_req_rdy = 1;
        for (int k = 1; k < 5; k++) begin
            check("full_order_val", back_req_val, 1);
            check("full_order_addr", back_req_addr, 'h100 + k);
            @(negedge clk);
        end
        check("full_drained", idle, 1);

        // async reset with 3 entries queued and a nack pending
        do_reset();
        drive(1, 1, 'h60, 'h11, 0, 0, 0); @(negedge clk);
        drive(1, 1, 'h70, 'h12, 0, 0, 0); @(negedge clk);
        drive(1, 0, 'h80, 'h13, 0, 0, 0); @(negedge clk);
        drive(1, 0, 'h60, 'h14, 0, 0, 0); @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ar_pre_rdy", mem_req_rdy, 0);
        #2 reset = 1;
        #1;
        check("ar_bval", back_req_val, 0);
        check("ar_rv", mem_resp_val, 0);
        check("ar_rn", mem_resp_nack, 0);
        check("ar_rt", mem_resp_tag, 0);
        check("ar_idle", idle, 1);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ar_post_bval", back_req_val, 0);
            check("ar_post_resp", {mem_resp_val, mem_resp_nack}, 0);
            check("ar_post_idle", idle, 1);
        end

        // randomized traffic vs reference model
        do_reset();
        m_q.delete(); m_np = 0; m_ntag = 0; m_rv = 0; m_rn = 0; m_rt = 0;
        for (int c = 0; c < 2000; c++) begin
            bit e_rdy, e_bval, acc, deq, hz, v, rw, brdy, rv;
            logic [31:0] a; logic [7:0] t, rt;
            e_rdy  = (m_q.size() != DEPTH) && !m_np;
            e_bval = (m_q.size() != 0);
            check("rnd_rdy", mem_req_rdy, e_rdy);
            check("rnd_bval", back_req_val, e_bval);
            if (e_bval) begin
                check("rnd_brw", back_req_rw, m_q[0].rw);
                check("rnd_baddr", back_req_addr, m_q[0].a);
                check("rnd_btag", back_req_tag, m_q[0].t);
            end
            check("rnd_rv", mem_resp_val, m_rv);
            check("rnd_rn", mem_resp_nack, m_rn);
            if (m_rv || m_rn) check("rnd_rt", mem_resp_tag, m_rt);
            check("rnd_idle", idle, (m_q.size() == 0) && !m_np);

            v = ($urandom_range(0, 3) != 0); rw = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 3)) << 4; t = 8'($urandom);
            brdy = ($urandom_range(0, 2) == 0); rv = ($urandom_range(0, 3) == 0);
            rt = 8'($urandom);
            drive(v, rw, a, t, brdy, rv, rt);

            acc = v && e_rdy;
            deq = e_bval && brdy;
            hz = 0;
            if (acc && !rw) foreach (m_q[j]) if (m_q[j].rw && m_q[j].a == a) hz = 1;
            if (deq) void'(m_q.pop_front());
            if (acc && !hz) m_q.push_back('{rw, a, t});
            m_rn = m_np && !rv;
            m_rt = rv ? rt : m_ntag;
            m_rv = rv;
            if (hz) begin m_np = 1; m_ntag = t; end
            else if (m_np && !rv) m_np = 0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
